seq_tx: RTL and testbench
=========================

SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter SYNC_W, default 4, sync-word width in bits.
REQ-002 Parameter SYNC_PAT, default 4'b1101, sync word, sent MSB first.
REQ-003 Parameter DATA_W, default 8, payload width in bits.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  payload offered.
REQ-007 in_data  in  DATA_W  payload word; sampled only on an accepted handshake.
REQ-008 in_ready  out  1  block can accept a payload this cycle.
REQ-009 out  out  1  registered serial bit stream.
REQ-010 busy  out  1  frame in progress (SYNC, DATA or PARITY state).
REQ-011 frame_done  out  1  one-cycle pulse marking frame end.

Function
REQ-012 States SHALL be IDLE, SYNC, DATA, PARITY and GAP.
REQ-013 A handshake SHALL be accepted on a rising edge where in_valid=1, in_ready=1 and rst=1.
- On acceptance, in_data SHALL be latched into an internal shift register.
- On acceptance, the state SHALL move to SYNC.
REQ-014 in_ready SHALL be 1 in IDLE and GAP while rst=1, else 0.
REQ-015 SYNC SHALL last SYNC_W cycles and drive SYNC_PAT on out, MSB first.
- The first sync bit SHALL appear in the cycle after acceptance.
REQ-016 DATA SHALL last DATA_W cycles and drive the latched payload on out, MSB first.
REQ-017 PARITY SHALL last 1 cycle and drive out = XOR of the latched payload bits (even parity).
REQ-018 GAP SHALL last 1 cycle with out=0 and frame_done=1.
- Next state: SYNC if a handshake is accepted in that cycle, else IDLE.
REQ-019 IDLE SHALL drive out=0, busy=0 and frame_done=0.
REQ-020 The frame period SHALL be SYNC_W+DATA_W+2 cycles with PARITY_EN (14 by default), SYNC_W+DATA_W+1 without (13).
- Back-to-back frames through GAP SHALL sustain this period with no extra idle cycle.
REQ-021 in_valid SHALL be ignored in SYNC, DATA and PARITY; a held in_valid SHALL be accepted at the next GAP or IDLE.
REQ-022 Changes to in_data after acceptance SHALL NOT affect the frame in flight.
REQ-023 The bit counter SHALL be ceil(log2(max(SYNC_W,DATA_W)+1)) bits wide.
- It SHALL reload to 0 on every state change.
- It SHALL NOT wrap inside a state.
REQ-024 A payload equal to SYNC_PAT SHALL be transmitted unmodified; no bit stuffing.

Reset
REQ-025 While rst=0 at a rising edge, all of the following SHALL hold on the next cycle:
- state=IDLE;
- out=0, busy=0, frame_done=0;
- shift register and bit counter cleared.
REQ-026 Reset mid-frame SHALL abandon the frame without completing it.
- The first cycle after rst returns to 1 SHALL be IDLE with in_ready=1.
REQ-027 in_ready SHALL be 0 in every cycle where rst=0.

Configuration
REQ-028 Macro SEQ_TX_PARITY_EN defined: the PARITY state SHALL exist as in REQ-017.
REQ-029 Macro SEQ_TX_PARITY_EN undefined:
- the PARITY state and its logic SHALL be absent;
- DATA SHALL go directly to GAP;
- the interface SHALL be unchanged.

Structure
REQ-030 Package seq_tx_pkg SHALL hold:
- the state enumeration typedef;
- default SYNC_W, SYNC_PAT and DATA_W constants.
REQ-031 Sub-module seq_tx_shreg (parallel-load, MSB-first shift register with load/shift enables) SHALL hold the payload.
- The FSM and counter SHALL remain in seq_tx.

Verification
REQ-032 Reset: hold rst=0 three cycles with in_valid=1.
- Required: out=0, busy=0, in_ready=0 and no acceptance.
- First cycle after release: in_ready=1.
REQ-033 Single frame, parity enabled: accept in_data=8'hA5.
- Next 13 out bits: 1,1,0,1, 1,0,1,0,0,1,0,1, 0.
- Then 1 GAP cycle with out=0 and frame_done=1.
- busy=1 for exactly 13 cycles.
REQ-034 Back-to-back: in_valid held 1 with 8'hFF then 8'h0D.
- Second frame's sync starts the cycle after GAP; period exactly 14.
- Parity bits: 0 for 8'hFF, 1 for 8'h0D.
REQ-035 Mid-frame reset: accept 8'h3C, drive rst=0 on the 6th DATA bit.
- Next cycle: out=0, busy=0.
- After release: a new frame with 8'h81 is sent correctly.
REQ-036 Payload = sync: accept 8'hDD.
- out = 1101 11011101 0, then GAP.
- in_data changed mid-frame has no effect.
REQ-037 Parity disabled build: accept 8'hA5.
- 12 bits 1101 10100101, then GAP; period 13.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the framed serial transmitter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a. Optional PARITY state controlled by macro SEQ_TX_PARITY_EN.
package seq_tx_pkg;

    localparam int               DEF_SYNC_W   = 4;
    localparam logic [3:0]       DEF_SYNC_PAT = 4'b1101;
    localparam int               DEF_DATA_W   = 8;

    // Frame sequencing states; PARITY only exists in parity-enabled builds.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_DATA   = 3'd2,
        ST_GAP    = 3'd3
`ifdef SEQ_TX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } state_t;

    // Bit counter width: enough to hold the longest state's bit index plus one.
    function automatic int cnt_width(input int sync_w, input int data_w);
        int longest;
        longest = (sync_w > data_w) ? sync_w : data_w;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/seq_tx_if.sv
// Payload handshake plus serial/status outputs of the transmitter.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready; payload moves only when both are high.
interface seq_tx_if
    import seq_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out;
    logic              busy;
    logic              frame_done;

    // Producer side: offers payloads, observes the serial stream.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out,
        input  busy,
        input  frame_done
    );

    // Transmitter side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out,
        output busy,
        output frame_done
    );

endinterface

// File: rtl/seq_tx_shreg.sv
// Parallel-load, MSB-first shift register holding the payload of the frame in flight.
// Latency: load/shift take effect on the next rising edge; msb is a direct register tap.
// Backpressure: none; load has priority over shift, zeros shift in at the LSB.
module seq_tx_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr_q;

    // Capture the payload on load, otherwise walk it towards the MSB one bit per shift.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= {sr_q[W-2:0], 1'b0};
        end
    end

    assign msb = sr_q[W-1];

endmodule

// File: rtl/seq_tx.sv
// Serialises one payload per frame: sync word, payload MSB first, optional parity, one GAP cycle.
// Latency: first sync bit on out the cycle after acceptance; out is registered. Macro SEQ_TX_PARITY_EN adds PARITY.
// Backpressure: in_ready only in IDLE/GAP out of reset; in_valid is ignored while a frame is in flight.
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int                SYNC_W   = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT,
    parameter int                DATA_W   = DEF_DATA_W
) (
    input  logic     clk,
    input  logic     rst,
    seq_tx_if.slave  bus
);

    localparam int CNT_W = cnt_width(SYNC_W, DATA_W);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               out_q;
    logic               out_d;
    logic               accept;
    logic               shift_en;
    logic               shreg_msb;
    logic [SYNC_W-1:0]  sync_sh;
`ifdef SEQ_TX_PARITY_EN
    logic               par_q;
`endif

    // Ready only when idle or in the closing GAP cycle, and never while reset is asserted.
    assign bus.in_ready = rst && ((state_q == ST_IDLE) || (state_q == ST_GAP));
    assign accept       = bus.in_valid && bus.in_ready;

    // Next state and bit counter; the counter restarts at 0 on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (cnt_q == CNT_W'(SYNC_W - 1)) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_GAP;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PARITY: begin
                state_d = ST_GAP;
            end
`endif
            ST_GAP: begin
                // Back-to-back frames go straight to SYNC, no idle bubble.
                state_d = accept ? ST_SYNC : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // IDLE holds the counter at 0; inside SYNC/DATA the terminal count forces a state change.
        if ((state_d == state_q) && (state_q != ST_IDLE)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Serial bit for the cycle being entered, so the registered out lines up with the state.
    always_comb begin
        out_d    = 1'b0;
        sync_sh  = SYNC_PAT << cnt_d;
        shift_en = (state_d == ST_DATA);
        case (state_d)
            ST_SYNC:   out_d = sync_sh[SYNC_W-1];
            ST_DATA:   out_d = shreg_msb;
`ifdef SEQ_TX_PARITY_EN
            ST_PARITY: out_d = par_q;
`endif
            default:   out_d = 1'b0;
        endcase
    end

    // State, counter and serial output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

`ifdef SEQ_TX_PARITY_EN
    // Even parity is taken at acceptance because the shift register consumes the payload.
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^bus.in_data;
        end
    end
`endif

    // Payload storage; later changes on in_data cannot reach the frame in flight.
    seq_tx_shreg #(
        .W (DATA_W)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift_en),
        .din   (bus.in_data),
        .msb   (shreg_msb)
    );

    assign bus.out        = out_q;
`ifdef SEQ_TX_PARITY_EN
    assign bus.busy       = (state_q == ST_SYNC) || (state_q == ST_DATA) || (state_q == ST_PARITY);
`else
    assign bus.busy       = (state_q == ST_SYNC) || (state_q == ST_DATA);
`endif
    assign bus.frame_done = (state_q == ST_GAP);

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: queue-based frame model compared every cycle, plus literal frame checks.
// Latency: model predicts each frame starting the cycle after an accepted handshake.
// Backpressure: model derives in_ready from whether a frame (other than its GAP) is still queued.
`timescale 1ns/1ps
module tb_seq_tx;
    import seq_tx_pkg::*;

    localparam int SW = 4;
    localparam int DW = 8;
`ifdef SEQ_TX_PARITY_EN
    localparam int          FBITS  = SW + DW + 1;
    localparam logic [31:0] EXP_A5 = 32'h1B4A;
    localparam logic [31:0] EXP_FF = 32'h1BFE;
    localparam logic [31:0] EXP_0D = 32'h1A1B;
    localparam logic [31:0] EXP_DD = 32'h1BBA;
    localparam logic [31:0] EXP_81 = 32'h1B02;
`else
    localparam int          FBITS  = SW + DW;
    localparam logic [31:0] EXP_A5 = 32'h0DA5;
    localparam logic [31:0] EXP_FF = 32'h0DFF;
    localparam logic [31:0] EXP_0D = 32'h0D0D;
    localparam logic [31:0] EXP_DD = 32'h0DDD;
    localparam logic [31:0] EXP_81 = 32'h0D81;
`endif
    localparam int PERIOD = FBITS + 1;

    logic clk = 1'b0;
    logic rst;

    seq_tx_if #(.DATA_W(DW)) bus ();

    seq_tx #(
        .SYNC_W   (SW),
        .SYNC_PAT (4'b1101),
        .DATA_W   (DW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: one {out, busy, frame_done} entry per expected cycle
    logic [2:0]    exp_q[$];
    bit            model_on = 1'b0;
    logic [SW-1:0] sync_pat_v = 4'b1101;

    function automatic bit model_ready();
        return (exp_q.size() == 0) || (exp_q[0] == 3'b001);
    endfunction

    task automatic push_frame(input logic [DW-1:0] d);
        for (int i = SW - 1; i >= 0; i--) exp_q.push_back({sync_pat_v[i], 2'b10});
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back({d[i], 2'b10});
`ifdef SEQ_TX_PARITY_EN
        exp_q.push_back({^d, 2'b10});
`endif
        exp_q.push_back(3'b001);
    endtask

    // Compare this cycle, then advance the model to what the next edge will produce.
    initial forever begin
        logic [2:0] e;
        logic       er;
        bit         rdy;
        @(negedge clk);
        if (model_on) begin
            e  = (exp_q.size() > 0) ? exp_q[0] : 3'b000;
            er = (rst === 1'b1) && model_ready();
            chk("cycle", 32'({bus.in_ready, bus.out, bus.busy, bus.frame_done}), 32'({er, e}));
        end
        if (rst !== 1'b1) begin
            exp_q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            rdy = model_ready();
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (rdy && bus.in_valid === 1'b1) push_frame(bus.in_data);
        end
    end

    // ---------------- recorder for the literal checks
    logic cap[$];
    int   rise_t[$];
    int   done_cnt = 0;
    int   cyc = 0;
    logic prev_busy = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (bus.busy === 1'b1) cap.push_back(bus.out);
        if (bus.busy === 1'b1 && prev_busy !== 1'b1) rise_t.push_back(cyc);
        if (bus.frame_done === 1'b1) done_cnt++;
        prev_busy = bus.busy;
    end

    task automatic clear_rec();
        cap.delete();
        rise_t.delete();
        done_cnt = 0;
    endtask

    function automatic logic [31:0] pack(input int s, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[30:0], ((s + i) < cap.size()) ? cap[s + i] : 1'b0};
        end
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a payload and return just after the edge that accepts it (call at posedge+1).
    task automatic offer(input logic [DW-1:0] d);
        bit got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 4 * PERIOD && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) got = 1'b1;
        end
        if (!got) chk("offer_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;

        // Reset held three edges with in_valid high.
        step(3);
        @(negedge clk);
        chk("rst_out",   32'(bus.out),      32'd0);
        chk("rst_busy",  32'(bus.busy),     32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        step(1);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("release_ready", 32'(bus.in_ready), 32'd1);
        step(1);

        // Single frame A5.
        clear_rec();
        offer(8'hA5);
        bus.in_valid = 1'b0;
        step(PERIOD + 3);
        chk("a5_bits",     pack(0, FBITS),     EXP_A5);
        chk("a5_busy_len", 32'(cap.size()),    32'(FBITS));
        chk("a5_done_cnt", 32'(done_cnt),      32'd1);

        // Back-to-back FF then 0D with in_valid held.
        clear_rec();
        offer(8'hFF);
        offer(8'h0D);
        bus.in_valid = 1'b0;
        step(2 * PERIOD + 3);
        chk("ff_bits",   pack(0, FBITS),     EXP_FF);
        chk("0d_bits",   pack(FBITS, FBITS), EXP_0D);
        chk("b2b_rises", 32'(rise_t.size()), 32'd2);
        if (rise_t.size() == 2) chk("b2b_period", 32'(rise_t[1] - rise_t[0]), 32'(PERIOD));
`ifdef SEQ_TX_PARITY_EN
        if (cap.size() >= 2 * FBITS) begin
            chk("ff_parity", 32'(cap[FBITS - 1]),     32'd0);
            chk("0d_parity", 32'(cap[2 * FBITS - 1]), 32'd1);
        end
`endif

        // Mid-frame reset on the 6th data bit of 3C, then a clean 81 frame.
        offer(8'h3C);
        bus.in_valid = 1'b0;
        step(9);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_bit6", 32'(bus.out), 32'd1);
        step(1);
        @(negedge clk);
        chk("mid_rst_out",  32'(bus.out),  32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        step(1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_release_ready", 32'(bus.in_ready), 32'd1);
        step(1);
        clear_rec();
        offer(8'h81);
        bus.in_valid = 1'b0;
        step(PERIOD + 3);
        chk("81_bits", pack(0, FBITS), EXP_81);

        // Payload equal to the sync word, with in_data disturbed mid-frame.
        clear_rec();
        offer(8'hDD);
        bus.in_valid = 1'b0;
        step(3);
        bus.in_data = 8'h00;
        step(5);
        bus.in_data = 8'hFF;
        step(PERIOD);
        chk("dd_bits",     pack(0, FBITS),  EXP_DD);
        chk("dd_done_cnt", 32'(done_cnt),   32'd1);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
